bit_stream_sync_ctrl: RTL and testbench
=======================================

Name: bit_stream_sync_ctrl

Overview:
Frame-synchronisation controller for the serial bit-stream path. It hunts for a fixed sync word in the incoming `din` stream and confirms that the word repeats at the frame period. It then declares `lock` and supervises lock, flagging missed sync words and dropping lock after consecutive misses. Downstream deframing logic consumes `lock`, `frame_start` and `bit_idx`.

Parameters:
- SYNC_W, 8: sync word width in bits (≥2).
- SYNC_PAT, 8'b1011_0001: sync word, MSB received first.
- FRAME_LEN, 32: bits per frame including the sync word (≥ SYNC_W+1).
- VERIFY_CNT, 3: on-period sync hits (including the first) required to lock (≥1).
- LOSS_CNT, 2: consecutive on-period misses that drop lock (≥1).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: bit-valid qualifier. A bit is accepted only when en=1.
- din, input, 1: serial data bit.
- lock, output, 1: frame lock indicator.
- state, output, 2: FSM state (0 HUNT, 1 VERIFY, 2 LOCKED, 3 CHECK).
- frame_start, output, 1: one-cycle pulse, first payload bit follows.
- bit_idx, output, $clog2(FRAME_LEN): current bit_cnt.
- sync_err, output, 1: one-cycle pulse on an on-period sync miss while lock=1.

Behaviour:
- Reset (rst_n=0 at a rising edge, regardless of en):
  - shift register and fill counter cleared;
  - state=HUNT; bit_cnt, hits and misses cleared;
  - lock=0, frame_start=0, sync_err=0.
  - A reset mid-operation takes effect at the next edge.
- en=0: shift register, counters and FSM hold. frame_start and sync_err are 0 that cycle.
- Pattern match (all on accepted bits only):
  - next_sr = {sr[SYNC_W-2:0], din}.
  - match_now = (next_sr == SYNC_PAT) AND fill ≥ SYNC_W-1, where fill counts accepted bits since reset and saturates.
  - match_now is evaluated on the accepted bit that completes the word.
- Bit counter:
  - Every accepted bit increments bit_cnt, wrapping FRAME_LEN-1 → 0.
  - The accepted bit with bit_cnt == FRAME_LEN-1 is the checkpoint, i.e. the expected last sync bit.
  - On a HUNT detect, bit_cnt is loaded with 0 (next bit is payload bit 0).
- HUNT: on match_now, load hits=1 and bit_cnt=0.
  - If VERIFY_CNT==1, go to LOCKED and set lock=1.
  - Otherwise go to VERIFY.
- VERIFY: only the checkpoint is examined. Matches elsewhere are ignored (no realignment).
  - Checkpoint hit: hits+1. When the new count equals VERIFY_CNT, go to LOCKED and set lock=1.
  - Checkpoint miss: go to HUNT and clear hits. The current bit is not re-hunted; search resumes with the next bit using the retained shift register.
- LOCKED: on each checkpoint, LOCKED remains while the sync word is received.
  - Checkpoint hit: stay.
  - Checkpoint miss: pulse sync_err and set misses=1.
    - If LOSS_CNT==1, go to HUNT and set lock=0.
    - Otherwise go to CHECK; lock stays 1.
- CHECK:
  - Checkpoint hit: go to LOCKED, clear misses.
  - Checkpoint miss: pulse sync_err, misses+1. When misses reaches LOSS_CNT, go to HUNT, set lock=0, clear counters.
- frame_start: registered pulse on the cycle after any checkpoint hit that leaves or keeps the FSM in LOCKED, including the entry into LOCKED.
- Output timing: all outputs are registered, so there is one-cycle latency from the deciding bit.

Decomposition:
- Package bit_stream_pkg holds:
  - typedef enum logic [1:0] sync_state_e {HUNT, VERIFY, LOCKED, CHECK};
  - default constants for SYNC_PAT, FRAME_LEN, VERIFY_CNT and LOSS_CNT.
- Sub-module bit_stream_match contains the shift register, fill counter and match_now output, with inputs en, din, clk and rst_n.
- bit_stream_sync_ctrl contains the FSM, bit/hit/miss counters and output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1 and random din → state=0, lock=0, frame_start=0, sync_err=0. After release, only zeros are sent → no VERIFY entry.
- Acquire: 4 frames of SYNC_PAT + 24 zero bits, en=1 → state=1 after bit 8. Checkpoint hits at bits 40 and 72; state=2 and lock=1 after bit 72; frame_start pulses at cycle 73 and again after bit 104.
- Decoy: during VERIFY, payload contains 1011_0001 at payload offset 10 → state stays 1, bit_idx is not realigned, lock is obtained at the original period.
- Single miss: while locked, one sync is corrupted to 1011_0000 → sync_err pulse once, state=3, lock=1. Next good sync → state=2 and frame_start pulse.
- Loss: two consecutive corrupted syncs → two sync_err pulses, state=0 and lock=0 after the second checkpoint. A fresh pattern re-enters VERIFY.
- en gating and reset:
  - With lock=1, drop en for 5 cycles mid-payload → bit_idx and state frozen, pulses 0. Next sync is still a hit.
  - Assert rst_n=0 in LOCKED → state=0 and lock=0 at the next edge.

Source files
------------

// File: rtl/bit_stream_pkg.sv
// Shared definitions for the bit-stream frame synchroniser.
// Contents:
//   sync_state_e     - FSM state encoding, also driven out on the state port
//   DEF_*            - default sync word, frame length and verify/loss thresholds
package bit_stream_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    CHECK  = 2'd3
  } sync_state_e;

  localparam int         DEF_SYNC_W     = 8;
  localparam logic [7:0] DEF_SYNC_PAT   = 8'b1011_0001;
  localparam int         DEF_FRAME_LEN  = 32;
  localparam int         DEF_VERIFY_CNT = 3;
  localparam int         DEF_LOSS_CNT   = 2;

endpackage

// File: rtl/bit_stream_sync_ctrl_if.sv
// Bus between the serial source, the frame synchroniser and the deframer.
// Signals:
//   en, din      - bit-valid qualifier and serial data bit (source -> sync)
//   lock, state  - lock indicator and FSM state (sync -> deframer)
//   frame_start  - one-cycle pulse; the first payload bit follows
//   bit_idx      - position of the current bit within the frame
//   sync_err     - one-cycle pulse on a missed sync word while locked
// Modports: master = bit source / observer, slave = synchroniser.
interface bit_stream_sync_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             en;
  logic             din;
  logic             lock;
  logic [1:0]       state;
  logic             frame_start;
  logic [IDX_W-1:0] bit_idx;
  logic             sync_err;

  modport master (
    output en, din,
    input  lock, state, frame_start, bit_idx, sync_err
  );

  modport slave (
    input  en, din,
    output lock, state, frame_start, bit_idx, sync_err
  );
endinterface

// File: rtl/bit_stream_match.sv
// Sync-word detector: shifts accepted bits in MSB-first and flags the
// accepted bit that completes the sync word.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   en, din    - bit-valid qualifier and serial data bit
//   match_now  - combinational; high during the accepted bit that completes
//                SYNC_PAT, once at least SYNC_W bits have arrived since reset
module bit_stream_match
  import bit_stream_pkg::*;
#(
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic match_now
);

  localparam int                FILL_W   = $clog2(SYNC_W) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);

  logic [SYNC_W-1:0] sr_reg;
  logic [SYNC_W-1:0] sr_next;
  logic [FILL_W-1:0] fill_reg;

  // Newest bit enters at the LSB so the first-received bit ends up as MSB.
  assign sr_next[0] = din;
  generate
    for (genvar gi = 1; gi < SYNC_W; gi++) begin : g_shift
      assign sr_next[gi] = sr_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      fill_reg <= '0;
    end else if (en) begin
      sr_reg <= sr_next;
      // Saturates once the register holds SYNC_W-1 real bits: the current
      // bit then completes a full window of genuine data.
      if (fill_reg != FILL_MAX) begin
        fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  assign match_now = en && (sr_next == SYNC_PAT) && (fill_reg == FILL_MAX);

endmodule

// File: rtl/bit_stream_sync_ctrl.sv
// Frame-synchronisation controller. Hunts for SYNC_PAT, verifies that it
// repeats every FRAME_LEN bits, then declares lock and supervises it,
// flagging missed sync words and dropping lock after LOSS_CNT consecutive
// misses.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - slave side of bit_stream_sync_ctrl_if (en/din in;
//                lock/state/frame_start/bit_idx/sync_err out, all registered)
module bit_stream_sync_ctrl
  import bit_stream_pkg::*;
#(
  parameter int                SYNC_W     = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = DEF_SYNC_PAT,
  parameter int                FRAME_LEN  = DEF_FRAME_LEN,
  parameter int                VERIFY_CNT = DEF_VERIFY_CNT,
  parameter int                LOSS_CNT   = DEF_LOSS_CNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_stream_sync_ctrl_if.slave bus
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam int               HIT_W    = $clog2(VERIFY_CNT + 1);
  localparam int               MISS_W   = $clog2(LOSS_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  sync_state_e       state_reg;
  logic [IDX_W-1:0]  bit_cnt_reg;
  logic [IDX_W-1:0]  bit_cnt_next;
  logic [HIT_W-1:0]  hits_reg;
  logic [MISS_W-1:0] misses_reg;
  logic              lock_reg;
  logic              frame_start_reg;
  logic              sync_err_reg;
  logic              match_now;
  logic              checkpoint;

  bit_stream_match #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .din       (bus.din),
    .match_now (match_now)
  );

  // The last bit of each frame period is where the sync word must end.
  assign checkpoint   = (bit_cnt_reg == LAST_IDX);
  assign bit_cnt_next = checkpoint ? '0 : bit_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      bit_cnt_reg     <= '0;
      hits_reg        <= '0;
      misses_reg      <= '0;
      lock_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      if (bus.en) begin
        bit_cnt_reg <= bit_cnt_next;
        case (state_reg)
          HUNT: begin
            if (match_now) begin
              // Align the frame: the next accepted bit is payload bit 0.
              hits_reg    <= HIT_W'(1);
              bit_cnt_reg <= '0;
              if (VERIFY_CNT == 1) begin
                state_reg       <= LOCKED;
                lock_reg        <= 1'b1;
                frame_start_reg <= 1'b1;
              end else begin
                state_reg <= VERIFY;
              end
            end
          end
          VERIFY: begin
            // Off-period matches are deliberately ignored: no realignment.
            if (checkpoint) begin
              if (match_now) begin
                hits_reg <= hits_reg + 1'b1;
                if (int'(hits_reg) + 1 >= VERIFY_CNT) begin
                  state_reg       <= LOCKED;
                  lock_reg        <= 1'b1;
                  frame_start_reg <= 1'b1;
                end
              end else begin
                state_reg <= HUNT;
                hits_reg  <= '0;
              end
            end
          end
          LOCKED: begin
            if (checkpoint) begin
              if (match_now) begin
                frame_start_reg <= 1'b1;
              end else begin
                sync_err_reg <= 1'b1;
                if (LOSS_CNT == 1) begin
                  state_reg  <= HUNT;
                  lock_reg   <= 1'b0;
                  hits_reg   <= '0;
                  misses_reg <= '0;
                end else begin
                  state_reg  <= CHECK;
                  misses_reg <= MISS_W'(1);
                end
              end
            end
          end
          CHECK: begin
            if (checkpoint) begin
              if (match_now) begin
                state_reg       <= LOCKED;
                misses_reg      <= '0;
                frame_start_reg <= 1'b1;
              end else begin
                sync_err_reg <= 1'b1;
                misses_reg   <= misses_reg + 1'b1;
                if (int'(misses_reg) + 1 >= LOSS_CNT) begin
                  state_reg  <= HUNT;
                  lock_reg   <= 1'b0;
                  hits_reg   <= '0;
                  misses_reg <= '0;
                end
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign bus.lock        = lock_reg;
  assign bus.state       = state_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.bit_idx     = bit_cnt_reg;
  assign bus.sync_err    = sync_err_reg;

endmodule

// File: tb/tb_bit_stream_sync_ctrl.sv
// Self-checking bench for bit_stream_sync_ctrl. A positional model (bit
// history queue, frame anchor, checkpoint = whole number of frames since the
// anchor) predicts every output; a negedge process compares each cycle, and
// literal checks after directed sequences pin the model.
module tb_bit_stream_sync_ctrl;
  import bit_stream_pkg::*;

  localparam int         SW    = 8;
  localparam int         FL    = 32;
  localparam int         VC    = 3;
  localparam int         LC    = 2;
  localparam int         IDX_W = 5;
  localparam logic [7:0] PAT   = 8'b1011_0001;
  localparam logic [7:0] BAD   = 8'b1011_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_stream_sync_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bit_stream_sync_ctrl #(
    .SYNC_W     (SW),
    .SYNC_PAT   (PAT),
    .FRAME_LEN  (FL),
    .VERIFY_CNT (VC),
    .LOSS_CNT   (LC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state
  int   n_bits;
  int   anchor;
  int   mode;
  int   hits;
  int   misses;
  bit   hist[$];
  logic exp_lock;
  logic exp_fs;
  logic exp_se;
  int   exp_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit window_is_pat();
    logic [7:0] p;
    p = PAT;
    if (hist.size() != SW) return 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (hist[i] != p[SW-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic d);
    bit m;
    bit cp;
    if (!r) begin
      n_bits = 0; anchor = 0; mode = 0; hits = 0; misses = 0;
      hist.delete();
      exp_lock = 1'b0; exp_fs = 1'b0; exp_se = 1'b0; exp_idx = 0;
      return;
    end
    exp_fs = 1'b0;
    exp_se = 1'b0;
    if (!e) return;
    n_bits++;
    hist.push_back(d);
    if (hist.size() > SW) void'(hist.pop_front());
    m  = window_is_pat();
    cp = ((n_bits - anchor) % FL) == 0;
    case (mode)
      0: if (m) begin
        anchor = n_bits; hits = 1;
        if (VC == 1) begin mode = 2; exp_lock = 1'b1; exp_fs = 1'b1; end
        else mode = 1;
      end
      1: if (cp) begin
        if (m) begin
          hits++;
          if (hits == VC) begin mode = 2; exp_lock = 1'b1; exp_fs = 1'b1; end
        end else begin
          mode = 0; hits = 0;
        end
      end
      2: if (cp) begin
        if (m) exp_fs = 1'b1;
        else begin
          exp_se = 1'b1; misses = 1;
          if (LC == 1) begin mode = 0; exp_lock = 1'b0; hits = 0; misses = 0; end
          else mode = 3;
        end
      end
      default: if (cp) begin
        if (m) begin mode = 2; misses = 0; exp_fs = 1'b1; end
        else begin
          exp_se = 1'b1; misses++;
          if (misses == LC) begin mode = 0; exp_lock = 1'b0; hits = 0; misses = 0; end
        end
      end
    endcase
    exp_idx = (n_bits - anchor) % FL;
  endtask

  // One cycle: drive inputs, clock edge, advance model, settle at negedge.
  task automatic step(input logic r, input logic e, input logic d);
    rst_n  = r;
    bus.en = e;
    bus.din = d;
    @(posedge clk);
    model_update(r, e, d);
    @(negedge clk);
  endtask

  task automatic send_zeros(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = SW - 1; i >= 0; i--) step(1'b1, 1'b1, w[i]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_state", 32'(bus.state), 32'(mode));
      chk("model_lock", 32'(bus.lock), 32'(exp_lock));
      chk("model_frame_start", 32'(bus.frame_start), 32'(exp_fs));
      chk("model_sync_err", 32'(bus.sync_err), 32'(exp_se));
      chk("model_bit_idx", 32'(bus.bit_idx), 32'(exp_idx));
    end
  end

  initial begin
    rst_n = 1'b0; bus.en = 1'b1; bus.din = 1'b0;
    model_update(1'b0, 1'b1, 1'b0);

    // Reset with random data
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    cmp_en = 1'b1;
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_lock", 32'(bus.lock), 0);
    chk("reset_fs", 32'(bus.frame_start), 0);
    chk("reset_se", 32'(bus.sync_err), 0);
    $display("reset done: state=%0d lock=%0d", bus.state, bus.lock);

    send_zeros(40);
    chk("zeros_hunt", 32'(bus.state), 0);
    $display("zeros: state=%0d", bus.state);

    // Acquire
    send_word(PAT);
    chk("acq_verify", 32'(bus.state), 1);
    send_zeros(24); send_word(PAT);
    chk("acq_hit2_state", 32'(bus.state), 1);
    send_zeros(24); send_word(PAT);
    chk("acq_lock_state", 32'(bus.state), 2);
    chk("acq_lock", 32'(bus.lock), 1);
    chk("acq_fs", 32'(bus.frame_start), 1);
    chk("acq_idx", 32'(bus.bit_idx), 0);
    send_zeros(24); send_word(PAT);
    chk("acq_fs2", 32'(bus.frame_start), 1);
    $display("acquire: state=%0d lock=%0d", bus.state, bus.lock);

    // Single miss then recovery
    send_zeros(24); send_word(BAD);
    chk("miss_se", 32'(bus.sync_err), 1);
    chk("miss_state", 32'(bus.state), 3);
    chk("miss_lock", 32'(bus.lock), 1);
    send_zeros(1);
    chk("miss_se_once", 32'(bus.sync_err), 0);
    send_zeros(23); send_word(PAT);
    chk("recover_state", 32'(bus.state), 2);
    chk("recover_fs", 32'(bus.frame_start), 1);
    $display("single miss: state=%0d lock=%0d", bus.state, bus.lock);

    // Loss of lock
    send_zeros(24); send_word(BAD);
    chk("loss1_state", 32'(bus.state), 3);
    send_zeros(24); send_word(BAD);
    chk("loss2_se", 32'(bus.sync_err), 1);
    chk("loss2_state", 32'(bus.state), 0);
    chk("loss2_lock", 32'(bus.lock), 0);
    send_word(PAT);
    chk("reacq_verify", 32'(bus.state), 1);
    $display("loss: state=%0d lock=%0d", bus.state, bus.lock);

    // Decoy inside payload during VERIFY
    send_zeros(10); send_word(PAT);
    chk("decoy_state", 32'(bus.state), 1);
    chk("decoy_idx", 32'(bus.bit_idx), 18);
    send_zeros(6); send_word(PAT);
    chk("decoy_hit2", 32'(bus.state), 1);
    send_zeros(24); send_word(PAT);
    chk("decoy_lock_state", 32'(bus.state), 2);
    chk("decoy_lock", 32'(bus.lock), 1);
    $display("decoy: state=%0d lock=%0d", bus.state, bus.lock);

    // en gating while locked
    send_zeros(10);
    chk("gate_idx_before", 32'(bus.bit_idx), 10);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("gate_idx_frozen", 32'(bus.bit_idx), 10);
    chk("gate_state", 32'(bus.state), 2);
    chk("gate_fs", 32'(bus.frame_start), 0);
    send_zeros(14); send_word(PAT);
    chk("gate_next_hit", 32'(bus.frame_start), 1);
    $display("en gating: idx=%0d state=%0d", bus.bit_idx, bus.state);

    // Reset while locked
    send_zeros(5);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_locked_state", 32'(bus.state), 0);
    chk("rst_locked_lock", 32'(bus.lock), 0);
    chk("rst_locked_idx", 32'(bus.bit_idx), 0);
    send_zeros(4);
    $display("reset in locked: state=%0d lock=%0d", bus.state, bus.lock);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
